// File: rtl/reg_host_bridge_pkg.sv
// Shared definitions for the UART-to-register-file command bridge:
// register indices, command byte layout, FSM states and the read-only check.
package reg_host_bridge_pkg;

   typedef enum logic [3:0] {
      REG_P         = 4'd0,
      REG_I         = 4'd1,
      REG_D         = 4'd2,
      REG_SP        = 4'd3,
      REG_OFF       = 4'd4,
      REG_I_UP      = 4'd5,
      REG_I_LOW     = 4'd6,
      REG_FLAGS     = 4'd7,
      REG_PID_O_VAL = 4'd8,
      REG_S_I       = 4'd13,
      REG_PID_O     = 4'd14,
      REG_PWM_O     = 4'd15
   } reg_idx_e;

   localparam int unsigned CMD_W_BIT   = 7;
   localparam int unsigned CMD_RSV_MSB = 6;
   localparam int unsigned CMD_RSV_LSB = 4;
   localparam int unsigned CMD_IDX_MSB = 3;

   typedef enum logic [3:0] {
      IDLE, WR_HI, WR_LO, WR_COMMIT, RD_WAIT, RD_CAP,
      TX_HI, TX_LO, TX_ACK, TX_NAK
   } state_e;

   // Sensor, PID output and PWM output are owned by the controller.
   function automatic logic is_read_only(input logic [3:0] idx);
      return (idx == REG_S_I) || (idx == REG_PID_O) || (idx == REG_PWM_O);
   endfunction

endpackage

// File: rtl/reg_host_bridge_if.sv
// UART byte streams and register-file ports of the command bridge.
// slave = bridge side, master = UART pair / register file side.
interface reg_host_bridge_if;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic        write_enable_o;
   logic [7:0]  w_addr_o;
   logic [15:0] w_data_o;
   logic [7:0]  r_addr_o;
   logic [15:0] r_data_i;
   logic        overrun_o;
   logic        busy_o;

   modport slave (
      input  rx_data_i, rx_valid_i, tx_ready_i, r_data_i,
      output tx_data_o, tx_valid_o, write_enable_o, w_addr_o, w_data_o,
             r_addr_o, overrun_o, busy_o
   );

   modport master (
      output rx_data_i, rx_valid_i, tx_ready_i, r_data_i,
      input  tx_data_o, tx_valid_o, write_enable_o, w_addr_o, w_data_o,
             r_addr_o, overrun_o, busy_o
   );
endinterface

// File: rtl/reg_host_bridge_frame_timeout.sv
// Inter-byte timeout down-counter for a partial write frame.
// Present only when BRIDGE_TIMEOUT_EN is defined.
`ifdef BRIDGE_TIMEOUT_EN
module frame_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
)(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_run,
   output logic o_expire
);
   localparam int unsigned   CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   // Loaded with N-1 so expiry lands on the N-th idle cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= LOAD;
      end else if (i_clear) begin
         r_cnt <= LOAD;
      end else if (i_run && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_expire = i_run && (r_cnt == '0);
endmodule
`endif

// File: rtl/reg_host_bridge.sv
// Decodes UART command bytes into register-file writes/reads and returns ACK/NAK
// or read data. Optional inter-byte timeout under BRIDGE_TIMEOUT_EN.
module reg_host_bridge
   import reg_host_bridge_pkg::*;
#(
   parameter logic [7:0] ACK_BYTE = 8'h06,
   parameter logic [7:0] NAK_BYTE = 8'h15
`ifdef BRIDGE_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
)(
   input  logic             clk_in,
   input  logic             reset,
   reg_host_bridge_if.slave bus
);
   state_e      r_state, w_next;
   logic [3:0]  r_idx;
   logic [7:0]  r_hi;
   logic [15:0] r_shadow;
   logic [7:0]  r_w_addr;
   logic [15:0] r_w_data;
   logic [7:0]  r_r_addr;
   logic        r_overrun;

   logic        w_rx, w_rx_write, w_rx_rsv_bad, w_waiting, w_drop, w_expire;
   logic [3:0]  w_rx_idx;

   assign w_rx         = bus.rx_valid_i;
   assign w_rx_write   = bus.rx_data_i[CMD_W_BIT];
   assign w_rx_rsv_bad = |bus.rx_data_i[CMD_RSV_MSB:CMD_RSV_LSB];
   assign w_rx_idx     = bus.rx_data_i[CMD_IDX_MSB:0];
   assign w_waiting    = (r_state == WR_HI) || (r_state == WR_LO);
   assign w_drop       = w_rx && !w_waiting && (r_state != IDLE);

`ifdef BRIDGE_TIMEOUT_EN
   frame_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame_timeout (
      .i_clk   (clk_in),
      .i_rst   (reset),
      .i_clear (!w_waiting || w_rx),
      .i_run   (w_waiting && !w_rx),
      .o_expire(w_expire)
   );
`else
   assign w_expire = 1'b0;
`endif

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_rx) begin
            if (w_rx_rsv_bad)    w_next = TX_NAK;
            else if (w_rx_write) w_next = WR_HI;
            else                 w_next = RD_WAIT;
         end
         WR_HI: if (w_rx) w_next = WR_LO;
                else if (w_expire) w_next = IDLE;
         WR_LO: if (w_rx) w_next = is_read_only(r_idx) ? TX_NAK : WR_COMMIT;
                else if (w_expire) w_next = IDLE;
         WR_COMMIT: w_next = TX_ACK;
         RD_WAIT:   w_next = RD_CAP;
         RD_CAP:    w_next = TX_HI;
         TX_HI:     if (bus.tx_ready_i) w_next = TX_LO;
         TX_LO, TX_ACK, TX_NAK: if (bus.tx_ready_i) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // Write address/data are only loaded for a committing write so they hold otherwise.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_idx     <= '0;
         r_hi      <= '0;
         r_shadow  <= '0;
         r_w_addr  <= '0;
         r_w_data  <= '0;
         r_r_addr  <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_drop) r_overrun <= 1'b1;
         case (r_state)
            IDLE: if (w_rx) begin
               r_idx <= w_rx_idx;
               if (!w_rx_write && !w_rx_rsv_bad) r_r_addr <= {4'h0, w_rx_idx};
            end
            WR_HI: if (w_rx) r_hi <= bus.rx_data_i;
            WR_LO: if (w_rx && !is_read_only(r_idx)) begin
               r_w_addr <= {4'h0, r_idx};
               r_w_data <= {r_hi, bus.rx_data_i};
            end
            RD_CAP:  r_shadow <= bus.r_data_i;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.tx_data_o = '0;
      case (r_state)
         TX_HI:   bus.tx_data_o = r_shadow[15:8];
         TX_LO:   bus.tx_data_o = r_shadow[7:0];
         TX_ACK:  bus.tx_data_o = ACK_BYTE;
         TX_NAK:  bus.tx_data_o = NAK_BYTE;
         default: bus.tx_data_o = '0;
      endcase
   end

   assign bus.tx_valid_o     = (r_state == TX_HI) || (r_state == TX_LO) ||
                               (r_state == TX_ACK) || (r_state == TX_NAK);
   assign bus.write_enable_o = (r_state == WR_COMMIT);
   assign bus.w_addr_o       = r_w_addr;
   assign bus.w_data_o       = r_w_data;
   assign bus.r_addr_o       = r_r_addr;
   assign bus.overrun_o      = r_overrun;
   assign bus.busy_o         = (r_state != IDLE);
endmodule

// File: tb/tb_reg_host_bridge.sv
// Scoreboard bench for reg_host_bridge: random frames against a register-map model,
// plus directed latency, backpressure, overrun and mid-frame reset cases.
module tb_reg_host_bridge;
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   logic clk;
   logic rst;
   reg_host_bridge_if bus();

   reg_host_bridge #(
      .ACK_BYTE(ACK),
      .NAK_BYTE(NAK)
`ifdef BRIDGE_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .clk_in(clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [7:0]  exp_tx[$];
   logic [23:0] exp_wr[$];
   logic [15:0] init_vals [16];
   logic [15:0] ref_regs [16];
   logic [15:0] env_regs [16];
   logic [15:0] rd_q;
   bit          env_loaded;
   int          ready_mode;
   bit          hold_pending;
   logic [7:0]  hold_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Register file environment: synchronous write, registered read.
   always @(posedge clk) begin
      if (!env_loaded) begin
         env_regs   <= init_vals;
         env_loaded <= 1'b1;
      end else if (bus.write_enable_o) begin
         env_regs[bus.w_addr_o[3:0]] <= bus.w_data_o;
      end
      rd_q <= env_regs[bus.r_addr_o[3:0]];
   end
   assign bus.r_data_i = rd_q;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       bus.tx_ready_i = ($urandom_range(0, 3) != 0);
         1:       bus.tx_ready_i = 1'b0;
         default: bus.tx_ready_i = 1'b1;
      endcase
   end

   // Monitor: pops expected tx bytes on handshake, expected writes on write strobe.
   always @(negedge clk) begin
      if (rst) begin
         hold_pending = 1'b0;
      end else begin
         if (bus.tx_valid_o) begin
            if (hold_pending) chk("tx_stable", bus.tx_data_o, hold_data);
            if (bus.tx_ready_i) begin
               hold_pending = 1'b0;
               if (exp_tx.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL tx_unexpected: got %0h expected none at %0t", bus.tx_data_o, $time);
               end else begin
                  chk("tx_byte", bus.tx_data_o, exp_tx.pop_front());
               end
            end else begin
               hold_pending = 1'b1;
               hold_data    = bus.tx_data_o;
            end
         end else begin
            hold_pending = 1'b0;
         end
         if (bus.write_enable_o) begin
            if (exp_wr.size() == 0) begin
               checks++; errors++;
               $display("FAIL wr_unexpected: got addr %0h data %0h expected none at %0t",
                        bus.w_addr_o, bus.w_data_o, $time);
            end else begin
               chk("wr_addr_data", {bus.w_addr_o, bus.w_data_o}, exp_wr.pop_front());
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      bus.rx_data_i  = b;
      bus.rx_valid_i = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (exp_tx.size() == 0 && exp_wr.size() == 0 && !bus.busy_o) return;
      end
      checks++; errors++;
      $display("FAIL %s_idle_timeout: got tx_left=%0d wr_left=%0d expected 0", tag,
               exp_tx.size(), exp_wr.size());
      exp_tx.delete();
      exp_wr.delete();
   endtask

   task automatic wait_txv(input string tag);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.tx_valid_o) return;
      end
      checks++; errors++;
      $display("FAIL %s_txv_timeout: got tx_valid=0 expected 1", tag);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tx_valid"}, bus.tx_valid_o, 0);
      chk({tag, "_tx_data"},  bus.tx_data_o, 0);
      chk({tag, "_we"},       bus.write_enable_o, 0);
      chk({tag, "_w_addr"},   bus.w_addr_o, 0);
      chk({tag, "_w_data"},   bus.w_data_o, 0);
      chk({tag, "_r_addr"},   bus.r_addr_o, 0);
      chk({tag, "_overrun"},  bus.overrun_o, 0);
      chk({tag, "_busy"},     bus.busy_o, 0);
   endtask

   // Reference model: rules of the command protocol applied to ref_regs.
   task automatic run_frame(input logic [7:0] cmd, input logic [15:0] data,
                            input bit lat, input bit do_wait);
      logic [3:0]  idx;
      logic [15:0] rv;
      idx = cmd[3:0];
      rv  = ref_regs[idx];
      if (cmd[6:4] != 3'b000) begin
         exp_tx.push_back(NAK);
         send_byte(cmd);
         if (lat) begin
            @(negedge clk);
            chk("nak_rsv_valid", bus.tx_valid_o, 1);
            chk("nak_rsv_data", bus.tx_data_o, NAK);
         end
      end else if (cmd[7]) begin
         if (idx >= 13) begin
            exp_tx.push_back(NAK);
         end else begin
            exp_wr.push_back({4'h0, idx, data});
            exp_tx.push_back(ACK);
            ref_regs[idx] = data;
         end
         send_byte(cmd);
         send_byte(data[15:8]);
         send_byte(data[7:0]);
         if (lat && idx >= 13) begin
            @(negedge clk);
            chk("we_ro_low", bus.write_enable_o, 0);
            chk("nak_ro_valid", bus.tx_valid_o, 1);
            chk("nak_ro_data", bus.tx_data_o, NAK);
         end else if (lat) begin
            @(negedge clk);
            chk("wr_lat_we", bus.write_enable_o, 1);
            chk("wr_lat_txv_early", bus.tx_valid_o, 0);
            @(negedge clk);
            chk("wr_lat_we_once", bus.write_enable_o, 0);
            chk("wr_lat_ack_valid", bus.tx_valid_o, 1);
            chk("wr_lat_ack_data", bus.tx_data_o, ACK);
            chk("wr_hold_addr", bus.w_addr_o, {4'h0, idx});
         end
      end else begin
         exp_tx.push_back(rv[15:8]);
         exp_tx.push_back(rv[7:0]);
         send_byte(cmd);
         if (lat) begin
            @(negedge clk);
            chk("rd_lat_addr", bus.r_addr_o, {4'h0, idx});
            chk("rd_lat_txv0", bus.tx_valid_o, 0);
            @(negedge clk);
            chk("rd_lat_txv1", bus.tx_valid_o, 0);
            @(negedge clk);
            chk("rd_lat_hi_valid", bus.tx_valid_o, 1);
            chk("rd_lat_hi_data", bus.tx_data_o, rv[15:8]);
         end
      end
      if (do_wait) wait_idle("frame");
   endtask

   initial begin
      logic [7:0]  cmd;
      logic [15:0] data;
      int          kind;
      rst            = 1'b1;
      bus.rx_valid_i = 1'b0;
      bus.rx_data_i  = '0;
      ready_mode     = 2;
      for (int i = 0; i < 16; i++) init_vals[i] = 16'($urandom);
      init_vals[3] = 16'hBEEF;
      ref_regs = init_vals;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      run_frame(8'h80, 16'h1234, 1, 1);

      ready_mode = 1;
      run_frame(8'h03, 16'h0000, 1, 0);
      repeat (5) @(negedge clk);
      chk("hold_valid", bus.tx_valid_o, 1);
      chk("hold_data", bus.tx_data_o, 8'hBE);
      ready_mode = 2;
      wait_idle("hold");

      run_frame(8'h8E, 16'hAA55, 1, 1);
      run_frame(8'h40, 16'h0000, 1, 1);

      chk("overrun_clear", bus.overrun_o, 0);
      ready_mode = 1;
      run_frame(8'h01, 16'h0000, 0, 0);
      wait_txv("overrun");
      send_byte(8'h81);
      @(negedge clk);
      chk("overrun_set", bus.overrun_o, 1);
      ready_mode = 2;
      wait_idle("overrun");
      run_frame(8'h05, 16'h0000, 1, 1);
      chk("overrun_sticky", bus.overrun_o, 1);

      send_byte(8'h87);
      send_byte(8'h11);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_wrlo");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_frame(8'h07, 16'h0000, 1, 1);
      run_frame(8'h87, 16'h2222, 1, 1);
      run_frame(8'h07, 16'h0000, 1, 1);

      ready_mode = 1;
      send_byte(8'h02);
      wait_txv("rst_txhi");
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_txhi");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ready_mode = 0;
      run_frame(8'h02, 16'h0000, 1, 1);

`ifdef BRIDGE_TIMEOUT_EN
      send_byte(8'h82);
      repeat (20) @(negedge clk);
      chk("timeout_idle", bus.busy_o, 0);
      run_frame(8'h02, 16'h0000, 1, 1);
`endif

      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 9));
         data = 16'($urandom);
         cmd  = 8'($urandom_range(0, 15));
         if (kind >= 4 && kind <= 6) cmd[7] = 1'b1;
         if (kind == 7) cmd[6:4] = 3'($urandom_range(1, 7));
         if (kind == 7) cmd[7] = 1'($urandom_range(0, 1));
         run_frame(cmd, data, 1, 1);
      end

      chk("overrun_after_reset", bus.overrun_o, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
